// File: rtl/rfid_tx_pkg.sv
// Shared types and default timing for the RFID reader transmit path.
package rfid_tx_pkg;

   localparam int unsigned AMP_W = 12;
   localparam int unsigned CNT_W = 16;

   localparam int unsigned DEF_DELIM_CLKS = 500;
   localparam int unsigned DEF_TARI_CLKS  = 500;
   localparam int unsigned DEF_PW_CLKS    = 250;
   localparam int unsigned DEF_D1_CLKS    = 875;
   localparam int unsigned DEF_TRCAL_CLKS = 2000;
   localparam int          DEF_AMP_HIGH   = 2047;
   localparam int          DEF_AMP_LOW    = 205;
   localparam int unsigned DEF_RAMP_STEP  = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELIM,
      ST_DATA0,
      ST_RTCAL,
      ST_TRCAL,
      ST_DATA,
      ST_DONE
   } tx_state_e;

endpackage

// File: rtl/amp_slew_limiter.sv
// Registered amplitude that walks toward a target by at most RAMP_STEP per clock,
// never overshooting, saturated to the signed AMP_W range.
module amp_slew_limiter
   import rfid_tx_pkg::*;
#(
   parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic signed [AMP_W-1:0] target_i,
   output logic signed [AMP_W-1:0] amp_o
);

   localparam int unsigned EXT_W      = AMP_W + 1;
   // Any step beyond the full-scale span behaves identically, so clamp it into EXT_W.
   localparam int unsigned STEP_CLAMP = (RAMP_STEP > 4095) ? 4095 : RAMP_STEP;
   localparam logic signed [EXT_W-1:0] STEP_S  = EXT_W'(STEP_CLAMP);
   localparam logic signed [EXT_W-1:0] AMP_MAX = EXT_W'((1 << (AMP_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] AMP_MIN = EXT_W'(-(1 << (AMP_W - 1)));

   logic signed [AMP_W-1:0] r_amp;
   logic signed [EXT_W-1:0] w_amp_x;
   logic signed [EXT_W-1:0] w_tgt_x;
   logic signed [EXT_W-1:0] w_diff;
   logic signed [EXT_W-1:0] w_sum;
   logic signed [EXT_W-1:0] w_next;

   always_comb begin
      w_amp_x = {r_amp[AMP_W-1], r_amp};
      w_tgt_x = {target_i[AMP_W-1], target_i};
      w_diff  = w_tgt_x - w_amp_x;
      if (w_diff > STEP_S) begin
         w_sum = w_amp_x + STEP_S;
      end else if (w_diff < -STEP_S) begin
         w_sum = w_amp_x - STEP_S;
      end else begin
         w_sum = w_tgt_x;
      end
      if (w_sum > AMP_MAX) begin
         w_next = AMP_MAX;
      end else if (w_sum < AMP_MIN) begin
         w_next = AMP_MIN;
      end else begin
         w_next = w_sum;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_amp <= '0;
      end else begin
         r_amp <= w_next[AMP_W-1:0];
      end
   end

   assign amp_o = r_amp;

endmodule

// File: rtl/pie_tx_encoder.sv
// PIE (EPC Gen2) reader-to-tag envelope generator: delimiter, data-0, RTcal,
// optional TRcal, then data symbols pulled from a valid/ready bit stream.
module pie_tx_encoder
   import rfid_tx_pkg::*;
#(
   parameter int unsigned DELIM_CLKS = DEF_DELIM_CLKS,
   parameter int unsigned TARI_CLKS  = DEF_TARI_CLKS,
   parameter int unsigned PW_CLKS    = DEF_PW_CLKS,
   parameter int unsigned D1_CLKS    = DEF_D1_CLKS,
   parameter int unsigned TRCAL_CLKS = DEF_TRCAL_CLKS,
   parameter int          AMP_HIGH   = DEF_AMP_HIGH,
   parameter int          AMP_LOW    = DEF_AMP_LOW,
   parameter int unsigned RAMP_STEP  = DEF_RAMP_STEP
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cw_en_i,
   input  logic                    start_i,
   input  logic                    preamble_i,
   input  logic                    bit_valid_i,
   input  logic                    bit_i,
   input  logic                    bit_last_i,
   output logic                    bit_ready_o,
   output logic signed [AMP_W-1:0] i_data_o,
   output logic signed [AMP_W-1:0] q_data_o,
   output logic                    tx_busy_o,
   output logic                    tx_done_o,
   output logic                    tx_err_o
);

   // Counter load values are length-1 so a segment ends on the clock the counter reads 0.
   localparam logic [CNT_W-1:0] LD_DELIM = CNT_W'(DELIM_CLKS - 1);
   localparam logic [CNT_W-1:0] LD_D0_HI = CNT_W'(TARI_CLKS - PW_CLKS - 1);
   localparam logic [CNT_W-1:0] LD_D1_HI = CNT_W'(D1_CLKS - PW_CLKS - 1);
   localparam logic [CNT_W-1:0] LD_RT_HI = CNT_W'(TARI_CLKS + D1_CLKS - PW_CLKS - 1);
   localparam logic [CNT_W-1:0] LD_TR_HI = CNT_W'(TRCAL_CLKS - PW_CLKS - 1);
   localparam logic [CNT_W-1:0] LD_LOW   = CNT_W'(PW_CLKS - 1);
   localparam logic signed [AMP_W-1:0] TGT_HIGH = AMP_W'(AMP_HIGH);
   localparam logic signed [AMP_W-1:0] TGT_LOW  = AMP_W'(AMP_LOW);

   tx_state_e        r_state;
   logic             r_low;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last;
   logic             r_pre;
   logic             r_bit_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   tx_state_e               w_state_nxt;
   logic                    w_low_nxt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic                    w_last_nxt;
   logic                    w_pre_nxt;
   logic                    w_take_bit;
   logic                    w_underrun;
   logic                    w_ready_nxt;
   logic                    w_seg_end;
   logic signed [AMP_W-1:0] w_target;

   assign w_seg_end = (r_cnt == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_low_nxt   = r_low;
      w_cnt_nxt   = r_cnt - CNT_W'(1);
      w_last_nxt  = r_last;
      w_pre_nxt   = r_pre;
      w_take_bit  = 1'b0;
      w_underrun  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (start_i) begin
               w_state_nxt = ST_DELIM;
               w_low_nxt   = 1'b1;
               w_cnt_nxt   = LD_DELIM;
               w_pre_nxt   = preamble_i;
               w_last_nxt  = 1'b0;
            end
         end
         ST_DELIM: begin
            if (w_seg_end) begin
               w_state_nxt = ST_DATA0;
               w_low_nxt   = 1'b0;
               w_cnt_nxt   = LD_D0_HI;
            end
         end
         ST_DATA0, ST_RTCAL, ST_TRCAL, ST_DATA: begin
            if (w_seg_end && !r_low) begin
               w_low_nxt = 1'b1;
               w_cnt_nxt = LD_LOW;
            end else if (w_seg_end) begin
               if (r_state == ST_DATA0) begin
                  w_state_nxt = ST_RTCAL;
                  w_low_nxt   = 1'b0;
                  w_cnt_nxt   = LD_RT_HI;
               end else if (r_state == ST_RTCAL && r_pre) begin
                  w_state_nxt = ST_TRCAL;
                  w_low_nxt   = 1'b0;
                  w_cnt_nxt   = LD_TR_HI;
               end else if (r_state == ST_DATA && r_last) begin
                  w_state_nxt = ST_DONE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_take_bit = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Bit handshake: the accepted bit picks the next symbol length.
      if (w_take_bit) begin
         if (bit_valid_i) begin
            w_state_nxt = ST_DATA;
            w_low_nxt   = 1'b0;
            w_last_nxt  = bit_last_i;
            w_cnt_nxt   = bit_i ? LD_D1_HI : LD_D0_HI;
         end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_underrun  = 1'b1;
         end
      end
      w_ready_nxt = w_low_nxt && (w_cnt_nxt == '0) &&
                    (((w_state_nxt == ST_RTCAL) && !w_pre_nxt) ||
                     (w_state_nxt == ST_TRCAL) ||
                     ((w_state_nxt == ST_DATA) && !w_last_nxt));
   end

   always_comb begin
      w_target = '0;
      case (r_state)
         ST_IDLE, ST_DONE: w_target = cw_en_i ? TGT_HIGH : '0;
         ST_DELIM:         w_target = TGT_LOW;
         default:          w_target = r_low ? TGT_LOW : TGT_HIGH;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_low       <= 1'b0;
         r_cnt       <= '0;
         r_last      <= 1'b0;
         r_pre       <= 1'b0;
         r_bit_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_low       <= w_low_nxt;
         r_cnt       <= w_cnt_nxt;
         r_last      <= w_last_nxt;
         r_pre       <= w_pre_nxt;
         r_bit_ready <= w_ready_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_done      <= (w_state_nxt == ST_DONE);
         r_err       <= w_underrun;
      end
   end

   amp_slew_limiter #(
      .RAMP_STEP (RAMP_STEP)
   ) u_slew (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .target_i (w_target),
      .amp_o    (i_data_o)
   );

   assign q_data_o    = '0;
   assign bit_ready_o = r_bit_ready;
   assign tx_busy_o   = r_busy;
   assign tx_done_o   = r_done;
   assign tx_err_o    = r_err;

endmodule

// File: tb/tb_pie_tx_encoder.sv
// Scoreboard bench for pie_tx_encoder: a segment-level envelope model feeds an
// expectation queue; a negedge monitor pops and compares every cycle.
module tb_pie_tx_encoder;

   localparam int DELIM = 5;
   localparam int TARI  = 8;
   localparam int PW    = 4;
   localparam int D1    = 14;
   localparam int TRCAL = 24;
   localparam int AHI   = 2047;
   localparam int ALO   = 205;
   localparam int SLOW  = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_i, cw_en_i, start_i, preamble_i, bit_valid_i, bit_i, bit_last_i;
   logic m_rdy, m_busy, m_done, m_err;
   logic s_rdy, s_busy, s_done, s_err;
   logic signed [11:0] m_i, m_q, s_i, s_q;

   pie_tx_encoder #(
      .DELIM_CLKS(DELIM), .TARI_CLKS(TARI), .PW_CLKS(PW), .D1_CLKS(D1),
      .TRCAL_CLKS(TRCAL), .AMP_HIGH(AHI), .AMP_LOW(ALO), .RAMP_STEP(4096)
   ) u_dut (
      .clk_i(clk), .rst_i(rst_i), .cw_en_i(cw_en_i), .start_i(start_i),
      .preamble_i(preamble_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
      .bit_last_i(bit_last_i), .bit_ready_o(m_rdy), .i_data_o(m_i), .q_data_o(m_q),
      .tx_busy_o(m_busy), .tx_done_o(m_done), .tx_err_o(m_err)
   );

   pie_tx_encoder #(
      .DELIM_CLKS(DELIM), .TARI_CLKS(TARI), .PW_CLKS(PW), .D1_CLKS(D1),
      .TRCAL_CLKS(TRCAL), .AMP_HIGH(AHI), .AMP_LOW(ALO), .RAMP_STEP(SLOW)
   ) u_ramp (
      .clk_i(clk), .rst_i(rst_i), .cw_en_i(cw_en_i), .start_i(start_i),
      .preamble_i(preamble_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
      .bit_last_i(bit_last_i), .bit_ready_o(s_rdy), .i_data_o(s_i), .q_data_o(s_q),
      .tx_busy_o(s_busy), .tx_done_o(s_done), .tx_err_o(s_err)
   );

   typedef struct {
      int i_data;
      int ramp;
      bit chk_ramp;
      bit rdy;
      bit busy;
      bit done;
      bit err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   last_tgt = 0;

   int f_tgt[$];
   bit f_rdy[$];
   int f_bidx[$];
   bit f_done[$];

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
      end
   endtask

   // Monitor: one expectation per clock, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_vec++;
         chk("i_data", int'(m_i), mon_e.i_data);
         chk("q_data", int'(m_q), 0);
         chk("bit_ready", int'(m_rdy), int'(mon_e.rdy));
         chk("tx_busy", int'(m_busy), int'(mon_e.busy));
         chk("tx_done", int'(m_done), int'(mon_e.done));
         chk("tx_err", int'(m_err), int'(mon_e.err));
         chk("slow_q_data", int'(s_q), 0);
         chk("slow_bit_ready", int'(s_rdy), int'(mon_e.rdy));
         chk("slow_tx_busy", int'(s_busy), int'(mon_e.busy));
         chk("slow_tx_done", int'(s_done), int'(mon_e.done));
         chk("slow_tx_err", int'(s_err), int'(mon_e.err));
         if (mon_e.chk_ramp) chk("ramp_i_data", int'(s_i), mon_e.ramp);
      end
   end

   // One clock of stimulus plus its expectation; instant-slew output lags target by one clock.
   task automatic step(input bit rst, input bit st, input bit pre, input bit cw,
                       input bit vld, input bit b, input bit lst, input int tgt,
                       input bit rdy, input bit busy, input bit done, input bit err,
                       input bit chkr, input int rampv);
      exp_t e;
      @(posedge clk);
      #1;
      rst_i = rst; start_i = st; preamble_i = pre; cw_en_i = cw;
      bit_valid_i = vld; bit_i = b; bit_last_i = lst;
      e.i_data = last_tgt; e.ramp = rampv; e.chk_ramp = chkr;
      e.rdy = rdy; e.busy = busy; e.done = done; e.err = err;
      exp_q.push_back(e);
      last_tgt = rst ? 0 : tgt;
   endtask

   task automatic idle(input int n, input bit cw);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, rb(), cw, rb(), rb(), rb(), cw ? AHI : 0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic add_seg(input int lvl, input int len);
      for (int i = 0; i < len; i++) begin
         f_tgt.push_back(lvl); f_rdy.push_back(1'b0);
         f_bidx.push_back(-1); f_done.push_back(1'b0);
      end
   endtask

   task automatic add_sym(input int len);
      add_seg(AHI, len - PW);
      add_seg(ALO, PW);
   endtask

   // Builds the whole frame as a list of per-clock targets, then plays it out.
   task automatic run_frame(input bit pre, input int n, input logic [15:0] bits,
                            input int u, input bit cw, input bit hold, input int abort_at);
      int idle_t;
      bit und;
      bit vld, b, lst, st;
      int bi;
      idle_t = cw ? AHI : 0;
      und = 1'b0;
      f_tgt.delete(); f_rdy.delete(); f_bidx.delete(); f_done.delete();
      add_seg(ALO, DELIM);
      add_sym(TARI);
      add_sym(TARI + D1);
      if (pre) add_sym(TRCAL);
      for (int i = 0; i < n; i++) begin
         f_rdy[f_rdy.size() - 1] = 1'b1;
         f_bidx[f_bidx.size() - 1] = i;
         if (i == u) begin
            und = 1'b1;
            break;
         end
         add_sym(bits[i] ? D1 : TARI);
      end
      if (!und) begin
         f_tgt.push_back(idle_t); f_rdy.push_back(1'b0);
         f_bidx.push_back(-1); f_done.push_back(1'b1);
      end
      step(1'b0, 1'b1, pre, cw, rb(), rb(), rb(), idle_t,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int k = 1; k <= f_tgt.size(); k++) begin
         if (k == abort_at) begin
            step(1'b1, rb(), rb(), cw, rb(), rb(), rb(), f_tgt[k-1],
                 f_rdy[k-1], 1'b1, f_done[k-1], 1'b0, 1'b0, 0);
            step(1'b0, 1'b0, rb(), cw, rb(), rb(), rb(), idle_t,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            return;
         end
         bi = f_bidx[k-1];
         vld = rb(); b = rb(); lst = rb();
         if (bi >= 0 && bi != u) begin
            vld = 1'b1; b = bits[bi]; lst = (bi == n - 1);
         end else if (bi >= 0) begin
            vld = 1'b0;
         end
         st = hold ? 1'b1 : rb();
         step(1'b0, st, rb(), cw, vld, b, lst, f_tgt[k-1],
              f_rdy[k-1], 1'b1, f_done[k-1], 1'b0, 1'b0, 0);
      end
      if (und)
         step(1'b0, 1'b0, rb(), cw, rb(), rb(), rb(), idle_t,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
   endtask

   initial begin
      bit          rcw, rpre;
      int          rn, ru;
      logic [15:0] rbits;
      int          rv;

      rst_i = 1'b1; cw_en_i = 1'b0; start_i = 1'b0; preamble_i = 1'b0;
      bit_valid_i = 1'b0; bit_i = 1'b0; bit_last_i = 1'b0;
      @(posedge clk);
      // Reset state, then slow-slew ramp up and down on carrier enable.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      for (int k = 0; k < 3; k++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      for (int k = 0; k < 36; k++) begin
         rv = (SLOW * k > AHI) ? AHI : SLOW * k;
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, AHI,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rv);
      end
      for (int k = 0; k < 36; k++) begin
         rv = (AHI - SLOW * k < 0) ? 0 : AHI - SLOW * k;
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rv);
      end
      idle(36, 1'b1);

      // Frame-sync 1,0(last)
      run_frame(1'b0, 2, 16'b01, -1, 1'b1, 1'b0, 0);
      idle(3, 1'b1);
      // Preamble with single bit 0(last)
      run_frame(1'b1, 1, 16'b0, -1, 1'b1, 1'b0, 0);
      idle(3, 1'b1);
      // Underrun at the first ready
      run_frame(1'b0, 3, 16'b101, 0, 1'b1, 1'b0, 0);
      idle(3, 1'b1);
      // start_i held high: one frame, restart in the first IDLE after DONE
      run_frame(1'b0, 2, 16'b10, -1, 1'b1, 1'b1, 0);
      run_frame(1'b1, 2, 16'b11, -1, 1'b1, 1'b0, 0);
      idle(3, 1'b1);
      // Reset during RTcal high segment
      run_frame(1'b0, 2, 16'b11, -1, 1'b1, 1'b0, 20);
      idle(3, 1'b1);
      // Carrier off between frames
      idle(2, 1'b0);
      run_frame(1'b0, 2, 16'b10, -1, 1'b0, 1'b0, 0);
      idle(3, 1'b0);

      for (int f = 0; f < 30; f++) begin
         rcw   = rb();
         rpre  = rb();
         rn    = int'($urandom_range(1, 6));
         rbits = 16'($urandom);
         ru    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn - 1)) : -1;
         idle(int'($urandom_range(1, 3)), rcw);
         run_frame(rpre, rn, rbits, ru, rcw, 1'b0, 0);
      end
      idle(3, 1'b1);

      @(posedge clk);
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
